// File: rtl/tflop_count_ctrl.sv
// Sequencing controller that turns an external WIDTH-bit T flip-flop bank into a
// loadable up/down counter by driving per-bit toggle enables from bank feedback.
module tflop_count_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             halt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_COUNT,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic               down_reg, down_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               wrap_reg, wrap_next;
  logic [WIDTH-1:0]   t_next;

  // Ripple terms: bit i toggles when every lower bit is 1 (up) or 0 (down).
  logic [WIDTH-1:0]   up_carry;
  logic [WIDTH-1:0]   dn_borrow;
  logic               q_all_ones;
  logic               q_zero;

  assign up_carry[0]  = 1'b1;
  assign dn_borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_ripple
      assign up_carry[gi]  = up_carry[gi-1] & q[gi-1];
      assign dn_borrow[gi] = dn_borrow[gi-1] & ~q[gi-1];
    end
  endgenerate

  assign q_all_ones = &q;
  assign q_zero     = ~|q;

  always_comb begin
    state_next = state_reg;
    down_next  = down_reg;
    data_next  = data_reg;
    len_next   = len_reg;
    wrap_next  = wrap_reg;
    t_next     = '0;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid && !reset) begin
          down_next = (cmd_op == 2'b10);
          data_next = cmd_data;
          len_next  = cmd_len;
          wrap_next = 1'b0;
          case (cmd_op)
            2'b00:   state_next = S_LOAD;
            2'b11:   state_next = S_CLEAR;
            default: state_next = S_COUNT;
          endcase
        end
      end
      S_LOAD: begin
        t_next     = q ^ data_reg;
        state_next = S_DONE;
      end
      S_CLEAR: begin
        t_next     = q;
        state_next = S_DONE;
      end
      S_COUNT: begin
        if (len_reg == '0) begin
          state_next = S_DONE;
        end else if (!halt) begin
          t_next   = down_reg ? dn_borrow : up_carry;
          len_next = len_reg - LEN_W'(1);
          // A step taken from the rollover value crosses all-ones <-> zero.
          if (down_reg ? q_zero : q_all_ones)
            wrap_next = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is high so the bank holds mid-operation.
  always_comb begin
    t         = reset ? '0 : t_next;
    cmd_ready = !reset && (state_reg == S_IDLE);
    busy      = !reset && (state_reg != S_IDLE);
    done      = !reset && (state_reg == S_DONE);
    wrap      = !reset && (state_reg == S_DONE) && wrap_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      down_reg  <= 1'b0;
      data_reg  <= '0;
      len_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      down_reg  <= down_next;
      data_reg  <= data_next;
      len_reg   <= len_next;
      wrap_reg  <= wrap_next;
    end
  end

endmodule

// File: tb/tb_tflop_count_ctrl.sv
// Bench for tflop_count_ctrl: a behavioural T-flop bank closes the loop, a vector
// table covers single commands, and hand sequences cover halt, reset and queuing.
module tb_tflop_count_ctrl;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             halt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             busy;
  logic             done;
  logic             wrap;

  logic             preset_en;
  logic [WIDTH-1:0] preset_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Bank model: each bit toggles when its enable is high; preset loads a start value.
  always @(posedge clk) begin
    if (preset_en) q <= preset_val;
    else           q <= q ^ t;
  end

  tflop_count_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .halt      (halt),
    .q         (q),
    .t         (t),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [WIDTH-1:0] v);
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Issue one command from IDLE and follow it to done (bounded wait).
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [LEN_W-1:0] len, output int lat,
                         output logic [WIDTH-1:0] first_t, output logic wrap_o,
                         output logic [WIDTH-1:0] q_o);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    #1;
    chk("ready_before_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    first_t = t;
    chk("busy_after_accept", busy, 1);
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      #1;
      lat++;
    end
    wrap_o = wrap;
    q_o    = q;
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
    #1;
    chk("ready_after_done", cmd_ready, 1);
  endtask

  typedef struct {
    string            name;
    logic [WIDTH-1:0] start_q;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] exp_first_t;
    int               exp_lat;
    logic [WIDTH-1:0] exp_q;
    logic             exp_wrap;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int               lat;
    logic [WIDTH-1:0] ft;
    logic             wr;
    logic [WIDTH-1:0] qf;

    vecs[0] = '{"load_A_from_5",   4'h5, 2'b00, 4'hA, 8'd0,   4'hF, 2,   4'hA, 1'b0};
    vecs[1] = '{"up5_from_D",      4'hD, 2'b01, 4'h0, 8'd5,   4'h3, 7,   4'h2, 1'b1};
    vecs[2] = '{"down3_from_2",    4'h2, 2'b10, 4'h0, 8'd3,   4'h3, 5,   4'hF, 1'b1};
    vecs[3] = '{"clear_from_F",    4'hF, 2'b11, 4'h0, 8'd0,   4'hF, 2,   4'h0, 1'b0};
    vecs[4] = '{"up0_from_7",      4'h7, 2'b01, 4'h0, 8'd0,   4'h0, 2,   4'h7, 1'b0};
    vecs[5] = '{"down4_from_3",    4'h3, 2'b10, 4'h0, 8'd4,   4'h1, 6,   4'hF, 1'b1};
    vecs[6] = '{"up16_from_0",     4'h0, 2'b01, 4'h0, 8'd16,  4'h1, 18,  4'h0, 1'b1};
    vecs[7] = '{"up3_from_0",      4'h0, 2'b01, 4'h0, 8'd3,   4'h1, 5,   4'h3, 1'b0};
    vecs[8] = '{"down255_from_0",  4'h0, 2'b10, 4'h0, 8'd255, 4'hF, 257, 4'h1, 1'b1};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_data   = '0;
    cmd_len    = '0;
    halt       = 1'b0;
    preset_en  = 1'b1;
    preset_val = 4'h0;

    // Reset-cycle outputs
    @(negedge clk);
    #1;
    chk("rst_t", t, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    @(negedge clk);
    reset     = 1'b0;
    preset_en = 1'b0;
    #1;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_t", t, 0);

    for (int i = 0; i < 9; i++) begin
      preset(vecs[i].start_q);
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].len, lat, ft, wr, qf);
      chk({vecs[i].name, "_first_t"}, ft, vecs[i].exp_first_t);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_q"}, qf, vecs[i].exp_q);
      chk({vecs[i].name, "_wrap"}, wr, vecs[i].exp_wrap);
      $display("vector %0d %s: first_t=%0h latency=%0d q=%0h wrap=%0d",
               i, vecs[i].name, ft, lat, qf, wr);
    end

    // Count up 10 from 0 with halt during cycles 4 and 5 after accept.
    preset(4'h0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_len   = 8'd10;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      halt      = (cyc == 4 || cyc == 5);
      #1;
      if (cyc == 1) chk("halt_seq_first_t", t, 1);
      if (cyc == 4 || cyc == 5) begin
        chk("halt_t_zero", t, 0);
        chk("halt_q_hold", q, 3);
      end
      if (cyc < 14) chk("halt_seq_no_early_done", done, 0);
      if (cyc == 14) begin
        chk("halt_seq_done", done, 1);
        chk("halt_seq_q", q, 4'hA);
        chk("halt_seq_wrap", wrap, 0);
      end
    end
    halt = 1'b0;
    $display("halt sequence: q=%0h", q);

    // Same count, reset asserted on step 4: bank must hold and no done follows.
    preset(4'h0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_len   = 8'd10;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      reset     = (cyc == 4);
      #1;
      if (cyc == 4) begin
        chk("rstmid_t_zero", t, 0);
        chk("rstmid_q", q, 3);
        chk("rstmid_ready", cmd_ready, 0);
      end
      if (cyc == 5) begin
        chk("rstmid_q_held", q, 3);
        chk("rstmid_ready_after", cmd_ready, 1);
        chk("rstmid_busy_after", busy, 0);
      end
      if (cyc >= 4) chk("rstmid_no_done", done, 0);
      if (cyc == 10) chk("rstmid_q_final", q, 3);
    end
    $display("reset-abort sequence: q=%0h", q);

    // Two commands queued behind a held cmd_valid: load 3, then count down 4.
    preset(4'h0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'h3;
    cmd_len   = 8'd0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cmd_op  = 2'b10;
        cmd_len = 8'd4;
      end
      if (cyc == 4) cmd_valid = 1'b0;
      #1;
      if (cyc == 1) chk("queue_stall_ready", cmd_ready, 0);
      if (cyc == 2) begin
        chk("queue_load_done", done, 1);
        chk("queue_load_q", q, 3);
      end
      if (cyc == 3) chk("queue_second_ready", cmd_ready, 1);
      if (cyc == 4) chk("queue_second_first_t", t, 1);
      if (cyc == 9) begin
        chk("queue_count_done", done, 1);
        chk("queue_count_q", q, 4'hF);
        chk("queue_count_wrap", wrap, 1);
      end
    end
    $display("queued sequence: q=%0h", q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
